// File: rtl/memory_single.sv
// memory_single
//   Single-port word RAM with synchronous write and registered synchronous
//   read. One bank of a multi-bank feature store.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous active-low reset
//   address_0  word address shared by read and write
//   data_0_in  write data
//   data_0_out registered read data (one clock of latency)
//   cs_0       chip select, active-high; requests ignored when low
//   we_0       write enable, active-high (takes priority over oe_0)
//   oe_0       read enable, active-high
module memory_single #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_0,
  input  logic [DATA_WIDTH-1:0] data_0_in,
  output logic [DATA_WIDTH-1:0] data_0_out,
  input  logic                  cs_0,
  input  logic                  we_0,
  input  logic                  oe_0
);

  // Word storage carries no reset. A per-word valid bit is cleared
  // asynchronously instead, so every word reads 0 the moment reset is
  // asserted, without a multi-cycle clearing sweep.
  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [RAM_DEPTH-1:0]  valid_q;
  logic [RAM_DEPTH-1:0]  valid_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  logic [31:0] addr_ext;
  logic        in_range;
  logic        wr_en;
  logic        rd_en;

  assign addr_ext = 32'(address_0);
  assign in_range = (addr_ext < 32'(RAM_DEPTH));

  // Gating with reset keeps a clock edge that coincides with reset
  // assertion from landing a write in the unreset storage array.
  assign wr_en = reset & cs_0 & we_0 & in_range;
  // A write in the same cycle wins; the output register then holds.
  assign rd_en = cs_0 & ~we_0 & oe_0;

  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[address_0] = 1'b1;
    end
  end

  // Out-of-range or never-written words read as 0, which also keeps
  // uninitialised storage from reaching the output.
  always_comb begin
    data_d = data_q;
    if (rd_en) begin
      if (in_range && valid_q[address_0]) begin
        data_d = mem_q[address_0];
      end else begin
        data_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[address_0] <= data_0_in;
    end
  end

  assign data_0_out = data_q;

endmodule

// File: tb/tb_memory_single.sv
module tb_memory_single;

  logic        clk;
  logic        reset;
  logic [7:0]  address_0;
  logic [31:0] data_0_in;
  logic        cs_0;
  logic        we_0;
  logic        oe_0;
  logic [31:0] dout_a;
  logic [31:0] dout_b;

  int errors;
  int checks;

  // Reference model: plain word arrays and the expected output register.
  logic [31:0] ma [256];
  logic [31:0] mb [256];
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  localparam int DEPTH_B = 200;

  memory_single #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(256)) dut (
    .clk(clk), .reset(reset), .address_0(address_0), .data_0_in(data_0_in),
    .data_0_out(dout_a), .cs_0(cs_0), .we_0(we_0), .oe_0(oe_0)
  );

  memory_single #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .reset(reset), .address_0(address_0), .data_0_in(data_0_in),
    .data_0_out(dout_b), .cs_0(cs_0), .we_0(we_0), .oe_0(oe_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    exp_a = '0;
    exp_b = '0;
  endtask

  // Drive one request, let one rising edge take it, then update the model.
  task automatic cycle(input logic c, input logic w, input logic o,
                       input logic [7:0] a, input logic [31:0] d);
    cs_0 = c; we_0 = w; oe_0 = o; address_0 = a; data_0_in = d;
    @(posedge clk);
    #1;
    if (c && w) begin
      ma[a] = d;
      if (int'(a) < DEPTH_B) mb[a] = d;
    end else if (c && o) begin
      exp_a = ma[a];
      exp_b = (int'(a) < DEPTH_B) ? mb[a] : 32'h0;
    end
    cs_0 = 1'b0; we_0 = 1'b0; oe_0 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] addrs [3];
    addrs[0] = 8'd0; addrs[1] = 8'd5; addrs[2] = 8'd255;
    reset = 1'b0;
    #2;
    checks++;
    if (dout_a !== 32'h0) begin
      errors++; $display("FAIL reset_out_a got=%h want=%h", dout_a, 32'h0);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b1, addrs[i], 32'h0);
      checks++;
      if (dout_a !== 32'h0 || dout_b !== 32'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d got=%h/%h want=0", addrs[i], dout_a, dout_b);
      end
    end
  endtask

  task automatic test_enables();
    cycle(1'b0, 1'b1, 1'b0, 8'd3, 32'hDEADBEEF);
    cycle(1'b1, 1'b1, 1'b0, 8'd9, 32'h0000_0005);
    cycle(1'b1, 1'b0, 1'b1, 8'd9, 32'h0);
    checks++;
    if (dout_a !== exp_a || exp_a !== 32'h5) begin
      errors++; $display("FAIL en_read9 got=%h want=%h", dout_a, 32'h5);
    end
    // oe_0 low: output must keep the value 5
    cycle(1'b1, 1'b0, 1'b0, 8'd3, 32'h0);
    checks++;
    if (dout_a !== 32'h5) begin
      errors++; $display("FAIL oe_hold got=%h want=%h", dout_a, 32'h5);
    end
    // cs_0 low with oe_0 high: still a hold
    cycle(1'b0, 1'b0, 1'b1, 8'd3, 32'h0);
    checks++;
    if (dout_a !== 32'h5) begin
      errors++; $display("FAIL cs_hold got=%h want=%h", dout_a, 32'h5);
    end
    cycle(1'b1, 1'b0, 1'b1, 8'd3, 32'h0);
    checks++;
    if (dout_a !== 32'h0 || dout_b !== 32'h0) begin
      errors++; $display("FAIL cs_off_write got=%h/%h want=0", dout_a, dout_b);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 128; i++) cycle(1'b1, 1'b1, 1'b0, 8'(i), 32'(i));
    for (int i = 0; i <= 128; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'(i), 32'h0);
      checks++;
      if (dout_a !== exp_a || dout_b !== exp_b) begin
        errors++;
        $display("FAIL seq_read addr=%0d got=%h/%h want=%h/%h", i, dout_a, dout_b, exp_a, exp_b);
      end
    end
    checks++;
    if (dout_a !== 32'h0) begin
      errors++; $display("FAIL seq_unwritten128 got=%h want=0", dout_a);
    end
  endtask

  task automatic test_priority();
    cycle(1'b1, 1'b1, 1'b0, 8'd20, 32'h11);
    cycle(1'b1, 1'b0, 1'b1, 8'd20, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 8'd7, 32'h22);
    checks++;
    if (dout_a !== 32'h11 || dout_b !== 32'h11) begin
      errors++; $display("FAIL prio_hold got=%h/%h want=11", dout_a, dout_b);
    end
    // back-to-back: read of the address written one cycle earlier
    cycle(1'b1, 1'b0, 1'b1, 8'd7, 32'h0);
    checks++;
    if (dout_a !== 32'h22 || dout_b !== 32'h22) begin
      errors++; $display("FAIL prio_read7 got=%h/%h want=22", dout_a, dout_b);
    end
  endtask

  task automatic test_boundary();
    cycle(1'b1, 1'b1, 1'b0, 8'd199, 32'hAA);
    cycle(1'b1, 1'b1, 1'b0, 8'd200, 32'hBB);
    cycle(1'b1, 1'b0, 1'b1, 8'd199, 32'h0);
    checks++;
    if (dout_b !== 32'hAA || dout_a !== 32'hAA) begin
      errors++; $display("FAIL bound_199 got=%h/%h want=aa", dout_a, dout_b);
    end
    cycle(1'b1, 1'b0, 1'b1, 8'd200, 32'h0);
    checks++;
    if (dout_b !== 32'h0) begin
      errors++; $display("FAIL bound_200_b got=%h want=0", dout_b);
    end
    checks++;
    if (dout_a !== 32'hBB) begin
      errors++; $display("FAIL bound_200_a got=%h want=bb", dout_a);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic c, w, o;
      logic [7:0] a;
      c = ($urandom_range(0, 7) != 0);
      w = ($urandom_range(0, 2) == 0);
      o = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255))
                                      : 8'($urandom_range(0, 31));
      cycle(c, w, o, a, $urandom);
      checks++;
      if (dout_a !== exp_a || dout_b !== exp_b) begin
        errors++;
        $display("FAIL rand n=%0d addr=%0d got=%h/%h want=%h/%h", n, a, dout_a, dout_b, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] addrs [5];
    addrs[0] = 8'd1; addrs[1] = 8'd7; addrs[2] = 8'd20;
    addrs[3] = 8'd100; addrs[4] = 8'd199;
    cycle(1'b1, 1'b1, 1'b0, 8'd100, 32'h1234_5678);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, addrs[i], 32'h0);
    checks++;
    if (dout_a !== exp_a || exp_a === 32'h0) begin
      errors++; $display("FAIL pre_reset_read got=%h want=%h", dout_a, exp_a);
    end
    // keep the sweep going while reset drops between edges
    cs_0 = 1'b1; oe_0 = 1'b1; address_0 = 8'd100;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dout_a !== 32'h0 || dout_b !== 32'h0) begin
      errors++; $display("FAIL async_clear got=%h/%h want=0", dout_a, dout_b);
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b1, addrs[i], 32'h0);
      checks++;
      if (dout_a !== 32'h0 || dout_b !== 32'h0) begin
        errors++;
        $display("FAIL post_reset addr=%0d got=%h/%h want=0", addrs[i], dout_a, dout_b);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    cs_0 = 1'b0; we_0 = 1'b0; oe_0 = 1'b0;
    address_0 = '0; data_0_in = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_enables();
    test_sequential();
    test_priority();
    test_boundary();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_single.md
Name:
memory_single

Overview:
Single-port, synchronous-write, synchronous-read word RAM with chip-select and output-enable.
- Used as one bank of a four-bank feature store; a controller round-robins writes across the banks and reads all banks in parallel at one address.
- Separate data-in and data-out buses; no tri-state.
- Registered read output, one clock of latency.

Parameters:
- DATA_WIDTH, 32, word width of data_0_in / data_0_out.
- ADDR_WIDTH, 8, width of address_0.
- RAM_DEPTH, 256, number of words; legal range 1..2**ADDR_WIDTH.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- address_0  input  ADDR_WIDTH  word address for both read and write.
- data_0_in  input  DATA_WIDTH  write data.
- data_0_out  output  DATA_WIDTH  registered read data.
- cs_0  input  1  chip select, active-high; when 0 the block ignores all requests.
- we_0  input  1  write enable, active-high.
- oe_0  input  1  output/read enable, active-high.

Behaviour:
- Reset (reset==0, asynchronous):
  - data_0_out cleared to 0 immediately.
  - All RAM words cleared to 0; clearing may complete over the reset-asserted period, but all words must read 0 after reset deasserts.
  - No write occurs while reset is asserted.
- Write: on posedge clk with cs_0=1 and we_0=1, mem[address_0] <= data_0_in, provided address_0 < RAM_DEPTH.
  - Out-of-range writes are silently dropped.
  - The written data is readable on the next cycle.
- Read: on posedge clk with cs_0=1, we_0=0 and oe_0=1, data_0_out <= mem[address_0].
  - Data is visible one cycle after the address is presented.
  - Out-of-range address gives data_0_out <= 0.
- Write priority: if cs_0=1, we_0=1 and oe_0=1 together, only the write is performed and data_0_out holds its previous value. There is no write-through.
- Hold: in all other cycles (cs_0=0, or we_0=0 with oe_0=0), data_0_out holds its last value and memory is unchanged.
- Back-to-back operation:
  - Reads may be issued every cycle at full throughput.
  - A read of an address written in the previous cycle returns the new data.
- Reset mid-operation:
  - Any in-flight read result is discarded; data_0_out becomes 0.
  - Any write in the same edge as reset assertion is dropped.
- No X propagation: with defined inputs after reset, data_0_out is never X.

Test Plan:
- Reset then read: assert reset=0, release; cs=1, oe=1, we=0, read addresses 0, 5 and 255 -> data_0_out=0 each, one cycle after the address.
- Sequential write/read: write data=i to addresses i=0..127 (cs=1, we=1); then we=0, oe=1, sweep read addresses 0..127 -> data_0_out equals the address value one cycle later; address 128 reads 0 (never written).
- Enables off: write 0xDEADBEEF to address 3 with cs_0=0 -> later read of address 3 returns 0. Read with oe_0=0 -> data_0_out holds its previous value.
- Write priority: hold data_0_out=0x11 from a prior read, then drive we=1, oe=1, addr=7, din=0x22 -> data_0_out stays 0x11; next read of address 7 -> 0x22.
- Boundary with RAM_DEPTH=200: write 0xAA to address 199 -> reads back 0xAA; write 0xBB to address 200 -> dropped, and read of address 200 returns 0.
- Async reset mid-stream: during a continuous read sweep, pulse reset low between clock edges -> data_0_out goes to 0 without waiting for a clock edge, and all previously written words read 0 after release.
